// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control-bundle pipeline registers:
//   ctrl_bundle_t  decoded control bundle carried between pipeline stages
//   CTRL_W         bundle width in bits
//   CTRL_BUBBLE    safe "do nothing" bundle (all enables low)
//   occ_state_t    occupancy state of a ctrl_pipe_reg (encoding = entry count)
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

    typedef struct packed {
        logic [4:0] BrOp;
        logic [2:0] DMCtrl;
        logic [3:0] ALUOp;
        logic [1:0] RUDataWrSrc;
        logic       ALUASrc;
        logic       ALUBSrc;
        logic       RUWr;
        logic       DMWr;
        logic       DMRd;
    } ctrl_bundle_t;

    localparam int           CTRL_W      = $bits(ctrl_bundle_t);
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Encoding equals the number of held bundles.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage : ctrl_pipe_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments on every clock edge with Inc = 1 and sticks at
// all-ones once it gets there.
// Ports:
//   Clk    in   clock, rising edge
//   Rst_n  in   asynchronous active-low reset, clears Count
//   Inc    in   count this edge
//   Count  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Inc,
    output logic [WIDTH-1:0] Count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (Inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Count = r_count;

endmodule : sat_counter

// File: rtl/ctrl_pipe_reg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_reg
// Pipeline register for decoded control bundles with a valid/ready handshake
// and a 2-entry skid buffer (main + skid). InReady, OutValid and OutData come
// straight from registers, so a downstream stall never creates a
// combinational ready path back upstream. Flush drops everything in flight.
// When nothing is held, OutData shows BUBBLE so downstream never sees stale
// write enables.
//
// Ports:
//   Clk         in   clock, rising edge
//   Rst_n       in   asynchronous active-low reset
//   InValid     in   upstream bundle valid
//   InReady     out  stage can accept a bundle (registered)
//   InData      in   upstream control bundle [W-1:0]
//   Flush       in   synchronous kill of held bundles and the current input
//   OutValid    out  held bundle valid
//   OutReady    in   downstream accepts
//   OutData     out  held bundle, or BUBBLE when OutValid = 0 [W-1:0]
//   Occupancy   out  bundles held, 0..2
//   FlushCount  out  cycles with Flush = 1, saturating [CNT_W-1:0]
//
// State table
//   state     | meaning
//   OCC_EMPTY | nothing held, outputs show BUBBLE
//   OCC_ONE   | main holds a bundle, skid empty
//   OCC_FULL  | main and skid both hold bundles, InReady = 0
// ---------------------------------------------------------------------------
module ctrl_pipe_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int             W      = CTRL_W,
    parameter logic [W-1:0]   BUBBLE = '0,
    parameter int             CNT_W  = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [W-1:0]     InData,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [W-1:0]     OutData,
    output logic [1:0]       Occupancy,
    output logic [CNT_W-1:0] FlushCount
);

    occ_state_t   r_state;
    occ_state_t   w_state_nxt;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic [W-1:0] w_main_d_nxt;
    logic [W-1:0] w_skid_d_nxt;

    logic w_main_v;
    logic w_skid_v;
    logic w_in_fire;
    logic w_out_fire;

    // Entry valid bits are decoded from the occupancy state so that the two
    // can never disagree.
    assign w_main_v   = (r_state == OCC_ONE) || (r_state == OCC_FULL);
    assign w_skid_v   = (r_state == OCC_FULL);

    assign w_in_fire  = InValid  && !w_skid_v;
    assign w_out_fire = w_main_v && OutReady;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= OCC_EMPTY;
            r_main_d <= BUBBLE;
            r_skid_d <= BUBBLE;
        end else begin
            r_state  <= w_state_nxt;
            r_main_d <= w_main_d_nxt;
            r_skid_d <= w_skid_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_main_d_nxt = r_main_d;
        w_skid_d_nxt = r_skid_d;

        if (Flush) begin
            // A concurrent out_fire already completed downstream; a concurrent
            // in_fire is simply not captured.
            w_state_nxt  = OCC_EMPTY;
            w_main_d_nxt = BUBBLE;
            w_skid_d_nxt = BUBBLE;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_d_nxt = InData;
                        w_state_nxt  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_out_fire && w_in_fire) begin
                        w_main_d_nxt = InData;
                    end else if (w_out_fire) begin
                        w_state_nxt  = OCC_EMPTY;
                    end else if (w_in_fire) begin
                        w_skid_d_nxt = InData;
                        w_state_nxt  = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    // InReady is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_main_d_nxt = r_skid_d;
                        w_state_nxt  = OCC_ONE;
                    end
                end
                default: begin
                    w_state_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    assign InReady   = !w_skid_v;
    assign OutValid  = w_main_v;
    assign OutData   = w_main_v ? r_main_d : BUBBLE;
    assign Occupancy = {1'b0, w_main_v} + {1'b0, w_skid_v};

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Inc   (Flush),
        .Count (FlushCount)
    );

endmodule : ctrl_pipe_reg

// File: doc/ctrl_pipe_reg.md
# ctrl_pipe_reg

Parametrised pipeline register for decoded control bundles, placed between any two stages (ID/EX, EX/MEM, MEM/WB) in the segmented core. It replaces per-stage control latches and adds three features:

- a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without combinational ready paths;
- a synchronous flush that drops everything in flight;
- a saturating flush counter for debug.

Whenever no valid bundle is held, the block presents a safe bubble value, so downstream stages never see stale write enables.

## Interface

Reset is asynchronous, active-low (`Rst_n`). Single clock, `Clk`.

Parameters:

- `W`, default 19: control bundle width in bits. 19 = BrOp 5 + DMCtrl 3 + ALUOp 4 + RUDataWrSrc 2 + five 1-bit flags.
- `BUBBLE`, default `'0`: value driven on `OutData` whenever `OutValid` = 0.
- `CNT_W`, default 8: `FlushCount` width.

Ports:

- `Clk`  in  1  clock, rising edge
- `Rst_n`  in  1  asynchronous active-low reset
- `InValid`  in  1  upstream bundle valid
- `InReady`  out  1  stage can accept a bundle; registered
- `InData`  in  W  upstream control bundle
- `Flush`  in  1  synchronous kill of all held bundles and the current input
- `OutValid`  out  1  held bundle valid
- `OutReady`  in  1  downstream accepts
- `OutData`  out  W  held bundle, or `BUBBLE` when invalid
- `Occupancy`  out  2  number of bundles held (0..2)
- `FlushCount`  out  `CNT_W`  cycles with `Flush` = 1, saturating at all-ones

## Operation

- Storage is two entries: `main` (drives the outputs) and `skid`, each with its own valid bit.
- Handshake signals:
  - `in_fire` = `InValid` & `InReady`
  - `out_fire` = `OutValid` & `OutReady`
  - `InReady` = !`skid_v`
  - `OutValid` = `main_v`
  - `OutData` = `main_v` ? `main_d` : `BUBBLE`
- Occupancy states and transitions, evaluated when `Flush` = 0:
  - **EMPTY (0):** `in_fire` → `main` ← `InData`, go to ONE.
  - **ONE (1):**
    - `out_fire` & `in_fire` → `main` ← `InData`, stay in ONE.
    - `out_fire` only → go to EMPTY.
    - `in_fire` only → `skid` ← `InData`, go to FULL.
    - neither → hold.
  - **FULL (2):** `InReady` = 0, so no `in_fire` is possible.
    - `out_fire` → `main` ← `skid`, `skid_v` ← 0, go to ONE.
    - otherwise hold.
- `Flush` = 1 has priority over everything:
  - at the edge, `main_v` ← 0 and `skid_v` ← 0, and `main_d` and `skid_d` ← `BUBBLE`;
  - an `InData` presented with `in_fire` in that cycle is dropped;
  - a simultaneous `out_fire` counts as completed, since downstream sampled it.
- Bundle ordering is strictly FIFO. No bundle is duplicated or lost except by `Flush`.
- `FlushCount` increments by 1 on each edge where `Flush` = 1, and stays at 2^`CNT_W` − 1 once reached.
- Reset values (asynchronous, while `Rst_n` = 0):
  - `main_v` = `skid_v` = 0
  - `OutValid` = 0, `OutData` = `BUBBLE`
  - `InReady` = 1, `Occupancy` = 0
  - `FlushCount` = 0
  - no transfer is recorded while `Rst_n` = 0
- Reset asserted mid-operation discards both entries immediately and asynchronously. It does not wait for a clock edge.
- `Occupancy` = `main_v` + `skid_v`.

## Timing

- Latency is 1 cycle: a bundle accepted at edge N is on `OutData` with `OutValid` = 1 after edge N.
- Throughput is 1 bundle/cycle when `OutReady` is held at 1.
- `InReady` depends only on registers, with no combinational path from `OutReady`. After a one-cycle downstream stall with continuous input, `InReady` drops for exactly one cycle after the skid fills.
- `OutValid` and `OutData` depend only on registers.
- `Flush` takes effect at the next edge: `OutValid` = 0 and `Occupancy` = 0 in the following cycle, and `InReady` = 1.

## Structure

- Shared package `ctrl_pipe_pkg` holds:
  - `ctrl_bundle_t`, a packed struct with BrOp[4:0], DMCtrl[2:0], ALUOp[3:0], RUDataWrSrc[1:0], ALUASrc, ALUBSrc, RUWr, DMWr, DMRd;
  - `CTRL_W` = `$bits(ctrl_bundle_t)`;
  - `CTRL_BUBBLE` = all-zero `ctrl_bundle_t`.
- One sub-module, `sat_counter` (parameter WIDTH; ports Clk, Rst_n, Inc, Count), used for `FlushCount`.
- Stages instantiate `ctrl_pipe_reg` with `W` = `CTRL_W` and `BUBBLE` = `CTRL_BUBBLE`.

## Test plan

1. **Reset.** Pulse `Rst_n` low mid-cycle with both entries full.
   - Immediately: `OutValid` = 0, `OutData` = 0, `Occupancy` = 0, `InReady` = 1, `FlushCount` = 0.
2. **Streaming.** Hold `OutReady` = 1 and push bundles 0x00011, 0x00022, 0x00033 on consecutive cycles.
   - They appear in order, one cycle later each.
   - `Occupancy` never exceeds 1.
3. **Stall and skid.** Push A=0x1A2B3 and B=0x04C5D with `OutReady` = 0.
   - `Occupancy` = 2, `InReady` = 0, `OutData` = A.
   - Raise `OutReady`: A, then B are delivered on consecutive cycles, and `InReady` returns to 1 after A leaves.
4. **Flush while full.** Flush with both entries full and `InValid` = 1 carrying C=0x7FFFF.
   - Next cycle: `OutValid` = 0, `OutData` = 0, `Occupancy` = 0.
   - C never appears on the output.
   - `FlushCount` = 1.
5. **Flush counter saturation.** With `CNT_W` = 4, hold `Flush` for 20 cycles.
   - `FlushCount` = 15 and holds.
   - Releasing `Flush` keeps it at 15.
6. **Random check.** Random `InValid`, `OutReady`, and `Flush` for 10k cycles against a FIFO scoreboard.
   - No loss or duplication outside flushes.
   - `OutData` equals `BUBBLE` whenever `OutValid` = 0.
